// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: one-byte SPI transaction sequencer for the 8-bit SPI master.
// Ports: req_valid/ready/data in, rsp_valid/ready/data out, abort, busy,
//   spi_start/load/read/data_in to master, spi_data_out from master, xfer_count.
// Build option: define SPI_CTRL_STATS_EN to enable the xfer_count counter.
// Async active-low reset on rst; all outputs except req_ready are registered.
module spi_master_ctrl #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  input  logic             abort,
  output logic             busy,
  output logic             spi_start,
  output logic             spi_load,
  output logic             spi_read,
  output logic [7:0]       spi_data_in,
  input  logic [7:0]       spi_data_out,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_SAMPLE,
    S_RESP,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [2:0] shift_cnt;
  logic [3:0] gap_cnt;
  logic       ready_q;
  logic       accept;
  logic       rsp_hs;

  logic       nxt_start;
  logic       nxt_load;
  logic       nxt_read;
  logic       nxt_busy;
  logic       nxt_rsp_valid;
  logic       nxt_ready;

  // ready_q tracks IDLE one edge late, so ready rises one clock
  // after reset release; abort masks it without a register delay
  assign req_ready = ready_q & ~abort;
  assign accept    = (state == S_IDLE) & req_valid & req_ready;
  assign rsp_hs    = (state == S_RESP) & rsp_ready & ~abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort && state != S_IDLE) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (accept) next_state = S_LOAD;
        S_LOAD:   next_state = S_SHIFT;
        S_SHIFT:  if (shift_cnt == 3'd7) next_state = S_LATCH;
        S_LATCH:  next_state = S_SAMPLE;
        S_SAMPLE: next_state = S_RESP;
        S_RESP: begin
          if (rsp_ready) begin
            next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP:    if (gap_cnt == GAP_LAST) next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  // Decode from next_state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    nxt_start     = 1'b0;
    nxt_load      = 1'b0;
    nxt_read      = 1'b0;
    nxt_busy      = (next_state != S_IDLE);
    nxt_rsp_valid = 1'b0;
    nxt_ready     = 1'b0;
    unique case (next_state)
      S_IDLE:   nxt_ready = 1'b1;
      S_LOAD: begin
        nxt_start = 1'b1;
        nxt_load  = 1'b1;
      end
      S_SHIFT:  nxt_start = 1'b1;
      S_LATCH, S_SAMPLE: begin
        nxt_start = 1'b1;
        nxt_read  = 1'b1;
      end
      S_RESP:   nxt_rsp_valid = 1'b1;
      S_GAP:    nxt_busy = 1'b1;
      default:  nxt_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_start <= 1'b0;
      spi_load  <= 1'b0;
      spi_read  <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      spi_start <= nxt_start;
      spi_load  <= nxt_load;
      spi_read  <= nxt_read;
      busy      <= nxt_busy;
      rsp_valid <= nxt_rsp_valid;
      ready_q   <= nxt_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_cnt <= 3'd0;
      gap_cnt   <= 4'd0;
    end else begin
      if (state == S_SHIFT) begin
        shift_cnt <= shift_cnt + 3'd1;
      end else begin
        shift_cnt <= 3'd0;
      end
      if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_data_in <= 8'h00;
    end else if (accept) begin
      spi_data_in <= req_data;
    end else if (next_state == S_IDLE) begin
      spi_data_in <= 8'h00;
    end
  end

  // master output register is valid during SAMPLE (copied in LATCH)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= 8'h00;
    end else if (state == S_SAMPLE && !abort) begin
      rsp_data <= spi_data_out;
    end
  end

`ifdef SPI_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_count <= '0;
    end else if (rsp_hs) begin
      xfer_count <= xfer_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign xfer_count = '0;
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl, two instances
// (GAP_CYCLES=1 and 0) checked every cycle against a transaction-phase model.
module tb_spi_master_ctrl;

  localparam int GAP0 = 1;
  localparam int GAP1 = 0;
`ifdef SPI_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic       abort     [2];
  logic       busy      [2];
  logic       spi_start [2];
  logic       spi_load  [2];
  logic       spi_read  [2];
  logic       miso      [2];
  logic [7:0] req_data  [2];
  logic [7:0] rsp_data  [2];
  logic [7:0] spi_din   [2];
  logic [7:0] sdo       [2];
  logic [15:0] xfer_count [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int load_cnt = 0;
  bit chk_en = 1'b0;

  // model: mk = cycles since accept (-1 = none), mg = gap cycles left
  int          mk   [2];
  int          mg   [2];
  bit          seen [2];
  logic [7:0]  mbyte [2];
  logic [7:0]  macc  [2];
  logic [7:0]  mrsp  [2];
  logic [15:0] mcnt  [2];

  // SPI master stand-in
  logic [7:0] msr  [2];
  logic [7:0] mout [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl #(.GAP_CYCLES(GAP0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_data(req_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]),
    .abort(abort[0]), .busy(busy[0]),
    .spi_start(spi_start[0]), .spi_load(spi_load[0]),
    .spi_read(spi_read[0]), .spi_data_in(spi_din[0]),
    .spi_data_out(sdo[0]), .xfer_count(xfer_count[0])
  );

  spi_master_ctrl #(.GAP_CYCLES(GAP1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_data(req_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]),
    .abort(abort[1]), .busy(busy[1]),
    .spi_start(spi_start[1]), .spi_load(spi_load[1]),
    .spi_read(spi_read[1]), .spi_data_in(spi_din[1]),
    .spi_data_out(sdo[1]), .xfer_count(xfer_count[1])
  );

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        msr[i]  <= 8'h00;
        mout[i] <= 8'h00;
      end else begin
        if (spi_start[i] && !spi_load[i] && !spi_read[i])
          msr[i] <= {miso[i], msr[i][7:1]};
        if (spi_read[i]) mout[i] <= msr[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) sdo[i] = spi_read[i] ? mout[i] : 8'h00;
  end

  always @(negedge clk) if (spi_load[0]) load_cnt <= load_cnt + 1;

  // Model: LOAD at k=1, shifts k=2..9 take MISO bit k-2 (first bit is
  // bit 0), LATCH k=10, SAMPLE k=11, response pending at k=12.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        mk[i]    <= -1;
        mg[i]    <= 0;
        seen[i]  <= 1'b0;
        mbyte[i] <= 8'h00;
        macc[i]  <= 8'h00;
        mrsp[i]  <= 8'h00;
        mcnt[i]  <= 16'h0000;
      end else begin
        seen[i] <= 1'b1;
        if (mk[i] < 0 && mg[i] == 0) begin
          if (req_valid[i] && seen[i] && !abort[i]) begin
            mk[i]    <= 1;
            mbyte[i] <= req_data[i];
          end
        end else if (abort[i]) begin
          mk[i] <= -1;
          mg[i] <= 0;
        end else if (mk[i] >= 1 && mk[i] <= 11) begin
          if (mk[i] >= 2 && mk[i] <= 9)
            macc[i][3'(mk[i] - 2)] <= miso[i];
          if (mk[i] == 11) mrsp[i] <= macc[i];
          mk[i] <= mk[i] + 1;
        end else if (mk[i] == 12) begin
          if (rsp_ready[i]) begin
            mk[i]   <= -1;
            mg[i]   <= (i == 0) ? GAP0 : GAP1;
            mcnt[i] <= mcnt[i] + 16'd1;
          end
        end else begin
          mg[i] <= mg[i] - 1;
        end
      end
    end
  end

  function automatic bit m_idle(input int i);
    return mk[i] < 0 && mg[i] == 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), busy[i], !m_idle(i));
        chk($sformatf("start%0d", i), spi_start[i],
            mk[i] >= 1 && mk[i] <= 11);
        chk($sformatf("load%0d", i), spi_load[i], mk[i] == 1);
        chk($sformatf("read%0d", i), spi_read[i],
            mk[i] == 10 || mk[i] == 11);
        chk($sformatf("rsp_valid%0d", i), rsp_valid[i], mk[i] == 12);
        chk($sformatf("req_ready%0d", i), req_ready[i],
            m_idle(i) && seen[i] && !abort[i]);
        chk($sformatf("xfer_count%0d", i), xfer_count[i],
            STATS ? mcnt[i] : 16'h0000);
        if (mk[i] == 12)
          chk($sformatf("rsp_data%0d", i), rsp_data[i], mrsp[i]);
        if (mk[i] >= 1 && mk[i] <= 11)
          chk($sformatf("data_in%0d", i), spi_din[i], mbyte[i]);
        if (m_idle(i))
          chk($sformatf("data_in_idle%0d", i), spi_din[i], 8'h00);
      end
    end
  end

  task automatic accept_req(input int i, input logic [7:0] b,
                            output bit ok);
    int n;
    req_valid[i] = 1'b1;
    req_data[i]  = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 40);
    ok = req_ready[i];
    chk($sformatf("accept_wait%0d", i), req_ready[i], 1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
  endtask

  // seq lists MISO bits in time order, MSB first
  task automatic xfer(input int i, input logic [7:0] b,
                      input logic [7:0] seq, input int hold,
                      output logic [7:0] got, output int lat,
                      output int st, output int acc);
    int n;
    bit ok;
    got = 8'h00;
    lat = -1;
    st  = 0;
    acc = 0;
    if (hold < 0) rsp_ready[i] = 1'b1;
    accept_req(i, b, ok);
    if (!ok) return;
    acc = cyc;
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) begin
      miso[i] = seq[7-j];
      @(posedge clk);
      #1;
    end
    miso[i] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[i] && n < 30);
    chk($sformatf("rsp_wait%0d", i), rsp_valid[i], 1);
    lat = cyc - acc;
    got = rsp_data[i];
    @(posedge clk);
    #1;
    if (hold >= 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (rsp_valid[i] && rsp_data[i] == got && !req_ready[i]) st++;
        @(posedge clk);
        #1;
      end
      rsp_ready[i] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int lat, st, a0, a1, a2, lc0, rv;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_data[i]  = 8'h00;
      rsp_ready[i] = 1'b0;
      abort[i]     = 1'b0;
      miso[i]      = 1'b0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_pre", req_ready[0], 0);
    @(posedge clk);
    #1;
    chk("ready_post", req_ready[0], 1);

    // reset in the middle of SHIFT
    accept_req(0, 8'h3C, ok);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t1_in_shift", spi_start[0], 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_outs",
        {busy[0], spi_start[0], spi_load[0], spi_read[0],
         rsp_valid[0], req_ready[0], spi_din[0]}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t1_ready_pre", req_ready[0], 0);
    @(posedge clk);
    #1;
    chk("t1_ready_post", req_ready[0], 1);

    // basic transfer, MISO 1,0,1,1,0,0,0,0
    lc0 = load_cnt;
    xfer(0, 8'hA5, 8'b1011_0000, 0, got, lat, st, a0);
    chk("t2_data", got, 8'h0D);
    chk("t2_latency", lat, 11);
    chk("t2_load_cycles", load_cnt - lc0, 1);

    // stalled response
    xfer(0, 8'h5A, 8'hFF, 20, got, lat, st, a0);
    chk("t3_data", got, 8'hFF);
    chk("t3_stable", st, 20);
    chk("t3_latency", lat, 11);

    // abort on the 4th SHIFT cycle
    accept_req(0, 8'h77, ok);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    abort[0] = 1'b1;
    @(posedge clk);
    #1 abort[0] = 1'b0;
    @(negedge clk);
    chk("t4_start_off", spi_start[0], 0);
    chk("t4_idle", busy[0], 0);
    rv = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid[0]) rv++;
    end
    chk("t4_no_rsp", rv, 0);
    @(posedge clk);
    #1;
    abort[0]     = 1'b1;
    req_valid[0] = 1'b1;
    req_data[0]  = 8'h11;
    @(negedge clk);
    chk("t4_idle_abort_ready", req_ready[0], 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_idle_abort_busy", busy[0], 0);
    @(posedge clk);
    #1;
    abort[0]     = 1'b0;
    req_valid[0] = 1'b0;
    xfer(0, 8'hC3, 8'b0110_1001, 0, got, lat, st, a0);
    chk("t4_after_data", got, 8'h96);

    xfer(0, 8'h01, 8'b0000_0001, 2, got, lat, st, a0);
    chk("t6_data_a", got, 8'h80);
    xfer(0, 8'hFE, 8'b1000_0000, 0, got, lat, st, a0);
    chk("t6_data_b", got, 8'h01);
    @(negedge clk);
    chk("t6_count", xfer_count[0], STATS ? 5 : 0);

    // back-to-back with GAP_CYCLES=0
    xfer(1, 8'h10, 8'b1111_0000, -1, got, lat, st, a0);
    chk("t5_data0", got, 8'h0F);
    xfer(1, 8'h20, 8'b0000_0001, -1, got, lat, st, a1);
    chk("t5_data1", got, 8'h80);
    xfer(1, 8'h30, 8'b0101_0101, -1, got, lat, st, a2);
    chk("t5_data2", got, 8'hAA);
    rsp_ready[1] = 1'b0;
    chk("t5_spacing01", a1 - a0, 13);
    chk("t5_spacing12", a2 - a1, 13);
    @(negedge clk);
    chk("t5_count", xfer_count[1], STATS ? 3 : 0);

    // back-to-back with one gap cycle
    xfer(0, 8'h44, 8'b1100_0000, -1, got, lat, st, a0);
    chk("gap_data0", got, 8'h03);
    xfer(0, 8'h55, 8'b0000_0011, -1, got, lat, st, a1);
    chk("gap_data1", got, 8'hC0);
    rsp_ready[0] = 1'b0;
    chk("gap_spacing", a1 - a0, 14);

    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
